// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM input capture peripheral: register map,
// CTRL/STATUS bit positions and the measurement state encoding.
package pwm_capture_pkg;

    localparam logic [1:0] CAP_CTRL   = 2'd0;
    localparam logic [1:0] CAP_STATUS = 2'd1;
    localparam logic [1:0] CAP_PERIOD = 2'd2;
    localparam logic [1:0] CAP_HIGH   = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_IE      = 1;
    localparam int CTRL_INV     = 2;
    localparam int CTRL_ONESHOT = 3;

    localparam int STAT_VALID  = 0;
    localparam int STAT_OVF    = 1;
    localparam int STAT_MISSED = 2;
    localparam int STAT_LEVEL  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } cap_state_t;

endpackage

// File: rtl/pwm_in_sync.sv
// Input conditioning for the capture block: 2-FF synchronizer, optional
// inversion and registered single-cycle rise/fall strobes.
module pwm_in_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_pwm,
    input  logic i_inv,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_sync1;
    logic r_sync2;
    logic r_dly;
    logic r_rise;
    logic r_fall;
    logic w_level;

    assign w_level = r_sync2 ^ i_inv;

    // Strobes are registered so an edge on the pin reaches the FSM exactly
    // three clocks later, one clock after LEVEL has already changed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_dly   <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync1 <= i_pwm;
            r_sync2 <= r_sync1;
            r_dly   <= w_level;
            r_rise  <= w_level & ~r_dly;
            r_fall  <= ~w_level & r_dly;
        end
    end

    assign o_level = w_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/pwm_capture.sv
// PWM input capture: measures period and high time of pwm_i in clk cycles
// and presents them on the TinyQV peripheral register bus.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pwm_i,
    input  logic [5:0]    address,
    input  logic [31:0]   data_in,
    input  logic [1:0]    data_write_n,
    input  logic [1:0]    data_read_n,
    output logic [31:0]   data_out,
    output logic          data_ready,
    output logic          user_interrupt,
    output logic [1:0]    o_dbg_state,
    output logic [CW-1:0] o_dbg_cnt
);

    // Bus handshake: a transfer is requested whenever the corresponding _n
    // pair is not 2'b11; reads complete combinationally in the same cycle
    // (data_ready mirrors the read request) and writes land on the next edge.

    cap_state_t    r_state;
    cap_state_t    w_state_nx;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_high_pend;
    logic [CW-1:0] r_period;
    logic [CW-1:0] r_high;
    logic [3:0]    r_ctrl;
    logic [2:0]    r_status;

    logic          w_level;
    logic          w_rise;
    logic          w_fall;
    logic          w_wr;
    logic          w_rd;
    logic          w_wr_ctrl;
    logic          w_wr_status;
    logic [2:0]    w_w1c;
    logic [CW-1:0] w_cnt_plus1;
    logic          w_cnt_max;
    logic          w_cnt_clr;
    logic          w_cnt_inc;
    logic          w_pend_ld;
    logic          w_capture;
    logic          w_ovf_set;
    logic [31:0]   w_rdata;
    logic          w_unused_bits;

    pwm_in_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_pwm   (pwm_i),
        .i_inv   (r_ctrl[CTRL_INV]),
        .o_level (w_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_wr        = (data_write_n != 2'b11);
    assign w_rd        = (data_read_n != 2'b11);
    assign w_wr_ctrl   = w_wr && (address[3:2] == CAP_CTRL);
    assign w_wr_status = w_wr && (address[3:2] == CAP_STATUS);
    assign w_w1c       = w_wr_status ? data_in[2:0] : 3'b000;

    assign w_unused_bits = ^{address[5:4], address[1:0], data_in[31:4]};

    // Captured values count the strobe cycle itself, so a 3-high/5-low
    // waveform reads back as HIGH=3, PERIOD=8.
    assign w_cnt_plus1 = r_cnt + {{(CW-1){1'b0}}, 1'b1};
    assign w_cnt_max   = (r_cnt == {CW{1'b1}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_clr  = 1'b0;
        w_cnt_inc  = 1'b0;
        w_pend_ld  = 1'b0;
        w_capture  = 1'b0;
        w_ovf_set  = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_clr = 1'b1;
                if (r_ctrl[CTRL_EN]) begin
                    w_state_nx = ARM;
                end
            end
            ARM: begin
                w_cnt_clr = 1'b1;
                if (!r_ctrl[CTRL_EN]) begin
                    w_state_nx = IDLE;
                end else if (w_rise) begin
                    w_state_nx = HIGH;
                end
            end
            HIGH: begin
                if (!r_ctrl[CTRL_EN]) begin
                    w_cnt_clr  = 1'b1;
                    w_state_nx = IDLE;
                end else if (w_cnt_max) begin
                    // Counter holds at all-ones; ARM clears it afterwards.
                    w_ovf_set  = 1'b1;
                    w_state_nx = ARM;
                end else begin
                    w_cnt_inc = 1'b1;
                    if (w_fall) begin
                        w_pend_ld  = 1'b1;
                        w_state_nx = LOW;
                    end
                end
            end
            LOW: begin
                if (!r_ctrl[CTRL_EN]) begin
                    w_cnt_clr  = 1'b1;
                    w_state_nx = IDLE;
                end else if (w_cnt_max) begin
                    w_ovf_set  = 1'b1;
                    w_state_nx = ARM;
                end else if (w_rise) begin
                    w_capture  = 1'b1;
                    w_cnt_clr  = 1'b1;
                    w_state_nx = HIGH;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            default: begin
                w_cnt_clr  = 1'b1;
                w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_high_pend <= '0;
            r_period    <= '0;
            r_high      <= '0;
        end else begin
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= w_cnt_plus1;
            end
            if (w_pend_ld) begin
                r_high_pend <= w_cnt_plus1;
            end
            if (w_capture) begin
                r_period <= w_cnt_plus1;
                r_high   <= r_high_pend;
            end
        end
    end

    // A software CTRL write takes priority over the one-shot auto-disable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl <= 4'b0000;
        end else if (w_wr_ctrl) begin
            r_ctrl <= data_in[3:0];
        end else if (w_capture && r_ctrl[CTRL_ONESHOT]) begin
            r_ctrl[CTRL_EN] <= 1'b0;
        end
    end

    // Hardware sets override a write-1-to-clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status <= 3'b000;
        end else begin
            r_status[STAT_VALID]  <= (r_status[STAT_VALID] & ~w_w1c[STAT_VALID]) | w_capture;
            r_status[STAT_OVF]    <= (r_status[STAT_OVF] & ~w_w1c[STAT_OVF]) | w_ovf_set;
            r_status[STAT_MISSED] <= (r_status[STAT_MISSED] & ~w_w1c[STAT_MISSED])
                                     | (w_capture & r_status[STAT_VALID]);
        end
    end

    always_comb begin
        w_rdata = 32'h0;
        if (w_rd) begin
            case (address[3:2])
                CAP_CTRL:   w_rdata[3:0]    = r_ctrl;
                CAP_STATUS: w_rdata[3:0]    = {w_level, r_status};
                CAP_PERIOD: w_rdata[CW-1:0] = r_period;
                default:    w_rdata[CW-1:0] = r_high;
            endcase
        end
    end

    assign data_out       = w_rdata;
    assign data_ready     = w_rd;
    assign user_interrupt = r_ctrl[CTRL_IE] & (r_status[STAT_VALID] | r_status[STAT_OVF]);
    assign o_dbg_state    = r_state;
    assign o_dbg_cnt      = r_cnt;

endmodule
